// File: rtl/light_link_transceiver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | light_link_transceiver_pkg                                         |
// | Shared state encodings and status bit positions for the LED link.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package light_link_transceiver_pkg;

    localparam int c_FRAME_SIZE_DEFAULT = 16;

    localparam int c_STAT_FRAMING = 0;
    localparam int c_STAT_PARITY  = 1;
    localparam int c_STAT_OVERRUN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_DONE   = 3'd5
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/light_rx_sampler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | light_rx_sampler                                                   |
// | Line synchroniser, mid-bit sampling RX FSM and sticky error flags. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module light_rx_sampler
    import light_link_transceiver_pkg::*;
#(
    parameter int FRAME_SIZE   = c_FRAME_SIZE_DEFAULT,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  signal,
    input  logic                  rx_ack,
    output logic [FRAME_SIZE-1:0] data_out,
    output logic                  irq_rx,
    output logic [2:0]            rx_status
);
    localparam int              c_TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int              c_BW     = $clog2(FRAME_SIZE + 1);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_T_HALF = c_TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic            c_ODD    = (PARITY_ODD != 0);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_state, w_state;
    logic [c_TW-1:0]        r_timer, w_timer;
    logic [c_BW-1:0]        r_bit, w_bit;
    logic [FRAME_SIZE-1:0]  r_word, w_word, r_data, w_data;
    logic                   r_par, w_par, r_par_err, w_par_err;
    logic                   r_armed, w_armed, r_irq, w_irq;
    logic [2:0]             r_status, w_status;
    logic                   w_line, w_stop_seen;

    assign w_line = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state     = r_state;
        w_timer     = r_timer;
        w_bit       = r_bit;
        w_word      = r_word;
        w_par       = r_par;
        w_par_err   = r_par_err;
        w_armed     = r_armed;
        w_stop_seen = 1'b0;
        case (r_state)
            RX_IDLE: begin
                // A line stuck high after a frame must drop before a new start counts.
                if (!w_line) begin
                    w_armed = 1'b1;
                end else if (r_armed) begin
                    w_state = RX_START;
                    w_timer = '0;
                end
            end
            RX_START: begin
                if (r_timer == c_T_HALF) begin
                    w_timer = '0;
                    if (w_line) begin
                        w_state   = RX_DATA;
                        w_bit     = c_BW'(FRAME_SIZE - 1);
                        w_word    = '0;
                        w_par     = 1'b0;
                        w_par_err = 1'b0;
                    end else begin
                        w_state = RX_IDLE;
                    end
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_timer == c_T_LAST) begin
                    w_timer = '0;
                    w_word  = (r_word << 1) | FRAME_SIZE'(w_line);
                    w_par   = r_par ^ w_line;
                    if (r_bit == '0) begin
                        w_state = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        w_bit = r_bit - 1'b1;
                    end
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            RX_PARITY: begin
                if (r_timer == c_T_LAST) begin
                    w_timer   = '0;
                    w_par_err = (w_line != (r_par ^ c_ODD));
                    w_state   = RX_STOP;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_timer == c_T_LAST) begin
                    w_timer     = '0;
                    w_state     = RX_IDLE;
                    w_armed     = 1'b0;
                    w_stop_seen = 1'b1;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            default: w_state = RX_IDLE;
        endcase
    end

    // An event coinciding with rx_ack survives the clear; it cannot raise overrun.
    always_comb begin
        w_status = rx_ack ? 3'b000 : r_status;
        w_irq    = rx_ack ? 1'b0 : r_irq;
        w_data   = r_data;
        if (w_stop_seen) begin
            if (w_line)    w_status[c_STAT_FRAMING] = 1'b1;
            if (r_par_err) w_status[c_STAT_PARITY]  = 1'b1;
            if (!w_line && !r_par_err) begin
                w_data = r_word;
                w_irq  = 1'b1;
                if (r_irq && !rx_ack) w_status[c_STAT_OVERRUN] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync    <= '0;
            r_state   <= RX_IDLE;
            r_timer   <= '0;
            r_bit     <= '0;
            r_word    <= '0;
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
            r_armed   <= 1'b0;
            r_data    <= '0;
            r_irq     <= 1'b0;
            r_status  <= 3'b000;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], signal};
            r_state   <= w_state;
            r_timer   <= w_timer;
            r_bit     <= w_bit;
            r_word    <= w_word;
            r_par     <= w_par;
            r_par_err <= w_par_err;
            r_armed   <= w_armed;
            r_data    <= w_data;
            r_irq     <= w_irq;
            r_status  <= w_status;
        end
    end

    assign data_out  = r_data;
    assign irq_rx    = r_irq;
    assign rx_status = r_status;

endmodule
`default_nettype wire

// File: rtl/light_link_transceiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | light_link_transceiver                                             |
// | Half-duplex LED/photodiode endpoint: framed serial TX plus RX.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module light_link_transceiver
    import light_link_transceiver_pkg::*;
#(
    parameter int FRAME_SIZE   = c_FRAME_SIZE_DEFAULT,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tx_enable,
    input  logic [FRAME_SIZE-1:0] data_in,
    output logic                  led,
    output logic                  irq_tx,
    input  logic                  signal,
    input  logic                  rx_ack,
    output logic [FRAME_SIZE-1:0] data_out,
    output logic                  irq_rx,
    output logic [2:0]            rx_status
);
    localparam int              c_TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int              c_BW     = $clog2(FRAME_SIZE + 1);
    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(CLKS_PER_BIT - 1);
    localparam logic            c_ODD    = (PARITY_ODD != 0);

    tx_state_t             r_state, w_state;
    logic [c_TW-1:0]       r_timer, w_timer;
    logic [c_BW-1:0]       r_bit, w_bit;
    logic [FRAME_SIZE-1:0] r_shift, w_shift;
    logic                  r_parity, w_parity, r_led, w_led, r_irq_tx, w_irq_tx;
    logic                  w_bit_end;

    assign w_bit_end = (r_timer == c_T_LAST);

    always_comb begin
        w_state  = r_state;
        w_timer  = r_timer;
        w_bit    = r_bit;
        w_shift  = r_shift;
        w_parity = r_parity;
        w_led    = r_led;
        w_irq_tx = r_irq_tx;
        if (r_state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP}) begin
            w_timer = w_bit_end ? '0 : r_timer + 1'b1;
        end
        case (r_state)
            TX_IDLE: begin
                if (tx_enable && !r_irq_tx) begin
                    w_state  = TX_START;
                    w_timer  = '0;
                    w_shift  = data_in;
                    w_parity = (^data_in) ^ c_ODD;
                    w_led    = 1'b1;
                end
            end
            TX_START: begin
                if (w_bit_end) begin
                    w_state = TX_DATA;
                    w_bit   = c_BW'(FRAME_SIZE - 1);
                    w_led   = r_shift[FRAME_SIZE-1];
                end
            end
            TX_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == '0) begin
                        w_state = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
                        w_led   = (PARITY_EN != 0) ? r_parity : 1'b0;
                    end else begin
                        w_bit   = r_bit - 1'b1;
                        w_shift = r_shift << 1;
                        w_led   = w_shift[FRAME_SIZE-1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_bit_end) begin
                    w_state = TX_STOP;
                    w_led   = 1'b0;
                end
            end
            TX_STOP: begin
                if (w_bit_end) begin
                    w_state  = TX_DONE;
                    w_irq_tx = 1'b1;
                end
            end
            TX_DONE: begin
                // Level handshake: the requester must drop tx_enable before the next frame.
                if (!tx_enable) begin
                    w_state  = TX_IDLE;
                    w_irq_tx = 1'b0;
                end
            end
            default: w_state = TX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= TX_IDLE;
            r_timer  <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_led    <= 1'b0;
            r_irq_tx <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_timer  <= w_timer;
            r_bit    <= w_bit;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_led    <= w_led;
            r_irq_tx <= w_irq_tx;
        end
    end

    assign led    = r_led;
    assign irq_tx = r_irq_tx;

    light_rx_sampler #(
        .FRAME_SIZE   (FRAME_SIZE),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_EN    (PARITY_EN),
        .PARITY_ODD   (PARITY_ODD),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clock     (clock),
        .reset     (reset),
        .signal    (signal),
        .rx_ack    (rx_ack),
        .data_out  (data_out),
        .irq_rx    (irq_rx),
        .rx_status (rx_status)
    );

endmodule
`default_nettype wire

// File: tb/tb_light_link_transceiver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_light_link_transceiver                                          |
// | Two cross-wired endpoints against a frame-level behavioural model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_light_link_transceiver;
    localparam int FS  = 16;
    localparam int CPB = 4;
    localparam int NB  = FS + 1 + 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, en_a, en_b, ack_a, ack_b, inj_on, inj_val;
    logic [FS-1:0] din_a, din_b, dout_a, dout_b;
    logic          led_a, led_b, irq_tx_a, irq_tx_b, irq_rx_a, irq_rx_b, sig_b;
    logic [2:0]    st_a, st_b;

    assign sig_b = inj_on ? inj_val : led_a;

    light_link_transceiver dut_a (
        .clock(clock), .reset(reset), .tx_enable(en_a), .data_in(din_a), .led(led_a),
        .irq_tx(irq_tx_a), .signal(led_b), .rx_ack(ack_a), .data_out(dout_a),
        .irq_rx(irq_rx_a), .rx_status(st_a));

    light_link_transceiver dut_b (
        .clock(clock), .reset(reset), .tx_enable(en_b), .data_in(din_b), .led(led_b),
        .irq_tx(irq_tx_b), .signal(sig_b), .rx_ack(ack_b), .data_out(dout_b),
        .irq_rx(irq_rx_b), .rx_status(st_b));

    // Frame-level model: line waveform per sender, delivered words per receiver.
    int            m_t[2];
    logic [NB-1:0] m_bits[2];
    logic [FS-1:0] m_word[2];
    logic          m_done[2];
    logic [FS-1:0] m_data[2];
    logic          m_irq[2];
    logic [2:0]    m_stat[2];
    int            m_quiet[2];
    int            total = 0;
    int            bad = 0;
    int            lat;

    function automatic logic [NB-1:0] frame_bits(input logic [FS-1:0] w, input logic flip_par,
                                                 input logic bad_stop);
        logic [NB-1:0] b;
        b[0] = 1'b1;
        for (int k = 0; k < FS; k++) b[1+k] = w[FS-1-k];
        b[FS+1] = (^w) ^ flip_par;
        b[FS+2] = bad_stop;
        return b;
    endfunction

    function automatic logic exp_led(input int i);
        return (m_t[i] >= 0) ? m_bits[i][m_t[i]/CPB] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rx_event(input int i, input logic good, input logic [FS-1:0] w,
                            input logic [2:0] errs);
        if (good) begin
            if (m_irq[i]) m_stat[i][2] = 1'b1;
            m_data[i] = w;
            m_irq[i]  = 1'b1;
        end else begin
            m_stat[i] = m_stat[i] | errs;
        end
        m_quiet[i] = 0;
    endtask

    task automatic model_step();
        logic          en_v[2];
        logic          ack_v[2];
        logic [FS-1:0] din_v[2];
        logic          ev[2];
        en_v[0] = en_a;   en_v[1] = en_b;
        ack_v[0] = ack_a; ack_v[1] = ack_b;
        din_v[0] = din_a; din_v[1] = din_b;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 1'b0;
            if (reset) begin
                m_t[i] = -1; m_done[i] = 1'b0; m_data[i] = '0;
                m_irq[i] = 1'b0; m_stat[i] = 3'b000; m_quiet[i] = 0;
            end else begin
                if (ack_v[i]) begin m_irq[i] = 1'b0; m_stat[i] = 3'b000; end
                if (m_done[i]) begin
                    if (!en_v[i]) m_done[i] = 1'b0;
                end else if (m_t[i] < 0) begin
                    if (en_v[i]) begin
                        m_t[i] = 0; m_word[i] = din_v[i];
                        m_bits[i] = frame_bits(din_v[i], 1'b0, 1'b0);
                    end
                end else begin
                    m_t[i]++;
                    if (m_t[i] == NB * CPB) begin m_t[i] = -1; m_done[i] = 1'b1; ev[i] = 1'b1; end
                end
            end
        end
        if (!reset) begin
            for (int i = 0; i < 2; i++) if (ev[i]) rx_event(1 - i, 1'b1, m_word[i], 3'b000);
            for (int r = 0; r < 2; r++) begin
                if (m_t[1-r] >= 0 || (r == 1 && inj_on)) m_quiet[r] = 0;
                else if (!ev[1-r] && m_quiet[r] < 1000) m_quiet[r]++;
            end
        end
    endtask

    task automatic compare_all();
        chk("led_a", led_a, exp_led(0));
        chk("led_b", led_b, exp_led(1));
        chk("irq_tx_a", irq_tx_a, m_done[0]);
        chk("irq_tx_b", irq_tx_b, m_done[1]);
        if (m_quiet[0] >= 3) begin
            chk("data_out_a", dout_a, m_data[0]);
            chk("irq_rx_a", irq_rx_a, m_irq[0]);
            chk("rx_status_a", st_a, m_stat[0]);
        end
        if (m_quiet[1] >= 3) begin
            chk("data_out_b", dout_b, m_data[1]);
            chk("irq_rx_b", irq_rx_b, m_irq[1]);
            chk("rx_status_b", st_b, m_stat[1]);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic send(input int i, input logic [FS-1:0] w, output int latency);
        int  n;
        logic seen;
        if (i == 0) begin en_a = 1'b1; din_a = w; end
        else        begin en_b = 1'b1; din_b = w; end
        latency = -1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            if (n == 10) begin
                if (i == 0) din_a = ~w; else din_b = ~w;
            end
            seen = (i == 0) ? irq_tx_a : irq_tx_b;
        end
        if (seen) latency = n;
        else chk("tx_timeout", (i == 0) ? irq_tx_a : irq_tx_b, 1);
        tick(); tick();
        chk("irq_tx_hold", (i == 0) ? irq_tx_a : irq_tx_b, 1);
        if (i == 0) en_a = 1'b0; else en_b = 1'b0;
        tick();
        chk("irq_tx_clear", (i == 0) ? irq_tx_a : irq_tx_b, 0);
        repeat (4) tick();
    endtask

    task automatic ack(input int i);
        if (i == 0) ack_a = 1'b1; else ack_b = 1'b1;
        tick();
        ack_a = 1'b0; ack_b = 1'b0;
        tick();
    endtask

    task automatic inject(input logic [NB-1:0] b);
        inj_on = 1'b1;
        for (int k = 0; k < NB; k++) begin
            inj_val = b[k];
            repeat (CPB) tick();
        end
        inj_val = 1'b0;
        repeat (6) tick();
        inj_on = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        din_a = '0; din_b = '0; inj_on = 1'b0; inj_val = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_t[i] = -1; m_done[i] = 1'b0; m_data[i] = '0; m_irq[i] = 1'b0;
            m_stat[i] = 3'b000; m_quiet[i] = 0; m_bits[i] = '0; m_word[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_led_a", led_a, 0);
        chk("reset_irq_tx_a", irq_tx_a, 0);
        chk("reset_data_out_b", dout_b, 16'h0000);
        chk("reset_irq_rx_b", irq_rx_b, 0);
        chk("reset_status_b", st_b, 3'b000);
        repeat (4) tick();

        send(0, 16'h5045, lat);
        chk("tx_latency", lat, 77);
        chk("b_word_5045", dout_b, 16'h5045);
        chk("b_irq_5045", irq_rx_b, 1);
        chk("b_status_5045", st_b, 3'b000);
        ack(1);

        send(1, 16'h5452, lat);
        chk("a_word_5452", dout_a, 16'h5452);
        chk("a_irq_5452", irq_rx_a, 1);
        ack(0);
        send(0, 16'h4121, lat);
        chk("b_word_4121", dout_b, 16'h4121);
        chk("b_status_4121", st_b, 3'b000);
        ack(1);

        send(0, 16'h1111, lat);
        send(0, 16'h2222, lat);
        chk("overrun_word", dout_b, 16'h2222);
        chk("overrun_status", st_b, 3'b100);
        chk("overrun_irq", irq_rx_b, 1);
        ack(1);
        chk("ack_irq", irq_rx_b, 0);
        chk("ack_status", st_b, 3'b000);

        inj_on = 1'b1; inj_val = 1'b1;
        tick();
        inj_val = 1'b0;
        repeat (10) tick();
        inj_on = 1'b0;
        repeat (4) tick();
        chk("glitch_irq", irq_rx_b, 0);
        chk("glitch_status", st_b, 3'b000);

        inject(frame_bits(16'hABCD, 1'b1, 1'b0));
        rx_event(1, 1'b0, '0, 3'b010);
        repeat (5) tick();
        chk("parity_status", st_b, 3'b010);
        chk("parity_word_held", dout_b, 16'h2222);
        chk("parity_irq", irq_rx_b, 0);
        ack(1);
        inject(frame_bits(16'h1234, 1'b0, 1'b1));
        rx_event(1, 1'b0, '0, 3'b001);
        repeat (5) tick();
        chk("framing_status", st_b, 3'b001);
        chk("framing_word_held", dout_b, 16'h2222);
        ack(1);

        en_a = 1'b1; din_a = 16'h0F0F;
        repeat (30) tick();
        chk("pre_reset_led", led_a, 1);
        reset = 1'b1; en_a = 1'b0;
        tick();
        chk("reset_mid_led", led_a, 0);
        chk("reset_mid_irq_tx", irq_tx_a, 0);
        reset = 1'b0;
        repeat (5) tick();
        send(0, 16'h7E81, lat);
        chk("post_reset_word", dout_b, 16'h7E81);
        chk("post_reset_irq", irq_rx_b, 1);
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
